// File: rtl/i2c_passthru_bus_arbiter_if.sv
// Purpose : signal bundle between the I2C passthru arbiter and its two upstream detectors.
// Latency : none (wires only).
// Backpressure: none; hold/stretch requests are carried as o_hold_* levels.
// Ports   : i_a/b_start (START pulses), i_a/b_idle, i_a/b_stuck (detector levels),
//           o_grant_a/b, o_hold_a/b, o_recov_a/b, o_busy (arbiter decisions).
// master = detector side / stimulus, slave = arbiter.
interface i2c_passthru_bus_arbiter_if;
  logic i_a_start;
  logic i_b_start;
  logic i_a_idle;
  logic i_b_idle;
  logic i_a_stuck;
  logic i_b_stuck;
  logic o_grant_a;
  logic o_grant_b;
  logic o_hold_a;
  logic o_hold_b;
  logic o_recov_a;
  logic o_recov_b;
  logic o_busy;

  modport master (
    output i_a_start, i_b_start, i_a_idle, i_b_idle, i_a_stuck, i_b_stuck,
    input  o_grant_a, o_grant_b, o_hold_a, o_hold_b, o_recov_a, o_recov_b, o_busy
  );

  modport slave (
    input  i_a_start, i_b_start, i_a_idle, i_b_idle, i_a_stuck, i_b_stuck,
    output o_grant_a, o_grant_b, o_hold_a, o_hold_b, o_recov_a, o_recov_b, o_busy
  );
endinterface

// File: rtl/i2c_passthru_bus_arbiter.sv
// Purpose : decides which upstream side (A/B) owns the shared downstream I2C bus.
// Latency : every output is registered, one cycle after the causing input.
// Backpressure: a requesting non-owner is held off by o_hold_* (SCL stretch) until granted.
// Ports   : i_clk, i_rst (sync, active-high); bus_if (slave modport) carries the
//           start/idle/stuck inputs and the grant/hold/recover/busy outputs.
module i2c_passthru_bus_arbiter #(
  parameter int GUARD_CYCLES = 16,
  parameter int WIDTH_GUARD  = 5
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  i2c_passthru_bus_arbiter_if.slave        bus_if
);
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT_A,
    ST_GRANT_B,
    ST_GUARD,
    ST_RECOVER
  } state_e;

  localparam logic [WIDTH_GUARD-1:0] GUARD_LOAD = WIDTH_GUARD'(GUARD_CYCLES - 1);

  state_e                 st_q, st_d;
  logic                   last_a_q, last_a_d;   // 1: A was the most recent owner
  logic                   pend_a_q, pend_a_d;
  logic                   pend_b_q, pend_b_d;
  logic [WIDTH_GUARD-1:0] cnt_q, cnt_d;
  logic                   prev_a_idle_q, prev_b_idle_q;
  logic                   recov_a_d, recov_b_d;
  logic                   grant_a_q, grant_b_q, hold_a_q, hold_b_q;
  logic                   recov_a_q, recov_b_q, busy_q;

  logic any_stuck, rise_a, rise_b, want_a, want_b, arb_now, pick_a, pick_b;

  always_comb begin
    any_stuck = bus_if.i_a_stuck | bus_if.i_b_stuck;
    rise_a    = bus_if.i_a_idle & ~prev_a_idle_q;
    rise_b    = bus_if.i_b_idle & ~prev_b_idle_q;
    // A start in the arbitration cycle counts the same as an already pending request.
    want_a    = pend_a_q | bus_if.i_a_start;
    want_b    = pend_b_q | bus_if.i_b_start;
    arb_now   = (st_q == ST_IDLE) || ((st_q == ST_GUARD) && (cnt_q == '0));
    // Tie goes to the side that did not own the bus last.
    pick_a    = want_a & (~want_b | ~last_a_q);
    pick_b    = want_b & ~pick_a;

    st_d      = st_q;
    last_a_d  = last_a_q;
    pend_a_d  = pend_a_q;
    pend_b_d  = pend_b_q;
    cnt_d     = cnt_q;
    recov_a_d = 1'b0;
    recov_b_d = 1'b0;

    if (any_stuck) begin
      // Stuck outranks everything; pending requests are dropped.
      st_d      = ST_RECOVER;
      pend_a_d  = 1'b0;
      pend_b_d  = 1'b0;
      recov_a_d = bus_if.i_a_stuck;
      recov_b_d = bus_if.i_b_stuck;
    end else if (arb_now) begin
      if (pick_a) begin
        st_d     = ST_GRANT_A;
        pend_a_d = 1'b0;
        pend_b_d = want_b;
      end else if (pick_b) begin
        st_d     = ST_GRANT_B;
        pend_b_d = 1'b0;
        pend_a_d = want_a;
      end else begin
        st_d = ST_IDLE;
      end
    end else begin
      case (st_q)
        ST_GRANT_A: begin
          if (bus_if.i_b_start) pend_b_d = 1'b1;
          // Owner's own repeated START is ignored; only its idle edge releases.
          if (rise_a) begin
            st_d     = ST_GUARD;
            last_a_d = 1'b1;
            cnt_d    = GUARD_LOAD;
          end
        end
        ST_GRANT_B: begin
          if (bus_if.i_a_start) pend_a_d = 1'b1;
          if (rise_b) begin
            st_d     = ST_GUARD;
            last_a_d = 1'b0;
            cnt_d    = GUARD_LOAD;
          end
        end
        ST_GUARD: begin
          cnt_d    = cnt_q - WIDTH_GUARD'(1);
          pend_a_d = want_a;
          pend_b_d = want_b;
        end
        ST_RECOVER: begin
          // Both stuck flags are clear here; the bus gets a full guard period.
          st_d  = ST_GUARD;
          cnt_d = GUARD_LOAD;
        end
        default: st_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st_q          <= ST_IDLE;
      last_a_q      <= 1'b0;
      pend_a_q      <= 1'b0;
      pend_b_q      <= 1'b0;
      cnt_q         <= '0;
      prev_a_idle_q <= 1'b1;
      prev_b_idle_q <= 1'b1;
      grant_a_q     <= 1'b0;
      grant_b_q     <= 1'b0;
      hold_a_q      <= 1'b0;
      hold_b_q      <= 1'b0;
      recov_a_q     <= 1'b0;
      recov_b_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      st_q          <= st_d;
      last_a_q      <= last_a_d;
      pend_a_q      <= pend_a_d;
      pend_b_q      <= pend_b_d;
      cnt_q         <= cnt_d;
      prev_a_idle_q <= bus_if.i_a_idle;
      prev_b_idle_q <= bus_if.i_b_idle;
      grant_a_q     <= (st_d == ST_GRANT_A);
      grant_b_q     <= (st_d == ST_GRANT_B);
      hold_a_q      <= pend_a_d;
      hold_b_q      <= pend_b_d;
      recov_a_q     <= recov_a_d;
      recov_b_q     <= recov_b_d;
      busy_q        <= (st_d != ST_IDLE);
    end
  end

  assign bus_if.o_grant_a = grant_a_q;
  assign bus_if.o_grant_b = grant_b_q;
  assign bus_if.o_hold_a  = hold_a_q;
  assign bus_if.o_hold_b  = hold_b_q;
  assign bus_if.o_recov_a = recov_a_q;
  assign bus_if.o_recov_b = recov_b_q;
  assign bus_if.o_busy    = busy_q;
endmodule

// File: doc/i2c_passthru_bus_arbiter.md
# i2c_passthru_bus_arbiter

Two-port ownership arbiter for the I2C passthru. Each upstream side (A, B) has its own idle/stuck detector-recoverer instance. This block consumes their status plus start pulses and decides which side owns the shared downstream bus. The non-owner that starts a transaction is held off by clock stretching, and the recover drivers are routed only while a side is stuck.

## Interface
Parameters:
- GUARD_CYCLES, 16, bus-free guard time in i_clk cycles between owner release and the next grant (≥1)
- WIDTH_GUARD, 5, counter width; must satisfy CEILING(LOG2(GUARD_CYCLES+1))

Ports:
- i_clk  in  1  single clock
- i_rst  in  1  reset; synchronous, active-high
- i_a_start  in  1  one-cycle pulse: START condition detected on side A
- i_b_start  in  1  same for side B
- i_a_idle  in  1  side A detector idle indication (level)
- i_b_idle  in  1  side B detector idle indication (level)
- i_a_stuck  in  1  side A detector stuck indication (level)
- i_b_stuck  in  1  side B detector stuck indication (level)
- o_grant_a  out  1  side A owns the downstream bus; passthru enabled A↔downstream
- o_grant_b  out  1  side B owns the downstream bus
- o_hold_a  out  1  stretch SCL low on side A (request pending, not granted)
- o_hold_b  out  1  stretch SCL low on side B
- o_recov_a  out  1  route side A recover drivers onto side A bus
- o_recov_b  out  1  route side B recover drivers onto side B bus
- o_busy  out  1  any grant, guard or recover in progress

## Operation
- All outputs are registered. Reset value of every output is 0. Reset state: ST_IDLE, last_owner=B (A wins the first tie), pend_a=pend_b=0, guard counter=0, prev idle flags=1.
- o_grant_a and o_grant_b are never both 1. Neither grant is ever 1 while either o_recov is 1.
- Owner release is on the **rising edge** of the owner's i_x_idle (prev=0, now=1), not on the level.
- Pending flags: pend_x is set by i_x_start when side X is not currently granted. It is cleared when X is granted, and cleared unconditionally on entry to ST_RECOVER. o_hold_x = pend_x.
- States:
  - ST_IDLE:
    - any stuck → ST_RECOVER.
    - Else if both starts (or both pending) → grant the side ≠ last_owner; the other side becomes pending.
    - Else a single start or pending → grant that side (ST_GRANT_A / ST_GRANT_B).
  - ST_GRANT_A:
    - any stuck → ST_RECOVER.
    - Else rising edge of i_a_idle → ST_GUARD, last_owner=A.
    - i_b_start → pend_b=1.
    - i_a_start while in this state is ignored (repeated START).
  - ST_GRANT_B: mirror of ST_GRANT_A.
  - ST_GUARD:
    - Counter loaded GUARD_CYCLES-1 on entry and decrements each cycle.
    - Any stuck → ST_RECOVER.
    - At 0: one pending → grant it; both pending → side ≠ last_owner; none → ST_IDLE.
    - Starts during guard set pend.
  - ST_RECOVER:
    - o_recov_x = i_x_stuck, registered each cycle; grants = 0, holds = 0.
    - When both stuck = 0 → ST_GUARD. last_owner is unchanged.
    - Starts during recover are ignored.
- Simultaneous events:
  - stuck beats idle-edge beats start.
  - Start and idle edge on the owner in the same cycle → release (ST_GUARD); the start is ignored.
- Reset mid-grant: all outputs 0 on the next edge; pending requests are lost.

## Timing
- Start pulse at cycle N in ST_IDLE → o_grant high at N+1; o_busy high at N+1.
- Non-owner start at N → o_hold high at N+1.
- Owner idle edge at N → o_grant low at N+1; grants stay low GUARD_CYCLES cycles; next grant (if pending) at N+1+GUARD_CYCLES, with its o_hold low in the same cycle.
- Stuck rising at N (any state) → grants low and o_recov_x high at N+1.
- Stuck clearing at N → o_recov low at N+1; first possible grant at N+1+GUARD_CYCLES.
- o_busy = 0 only in ST_IDLE.

## Test plan
- Reset: hold i_rst=1 for 3 cycles with random inputs → all outputs 0. Release, pulse i_a_start → o_grant_a=1 on the next cycle.
- Contention: grant A, pulse i_b_start → o_hold_b=1. Raise i_a_idle → o_grant_a=0, then o_grant_b=1 exactly 16 cycles later with o_hold_b=0 in the same cycle.
- Tie / round-robin: from reset, pulse both starts in one cycle → grant A, hold B. After A releases and B releases, pulse both again → grant A, because last_owner=B after B's release.
- Stuck during grant: while B is granted, assert i_a_stuck → o_grant_b=0, o_recov_a=1 next cycle, pend flags cleared. Deassert stuck → o_recov_a=0, o_busy=1 for 16 cycles, then 0.
- Simultaneous: owner A idle edge and i_a_start in the same cycle → release takes effect and no re-grant without a pend. Stuck and start in the same cycle in ST_IDLE → ST_RECOVER with no grant.
- Mutual exclusion: random starts/idles/stucks over 10k cycles → assertion holds: grant_a & grant_b never 1, and grant & recov never 1.
